// File: rtl/fpu_sp_divider.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_sp_divider
//  Description : Iterative single-precision IEEE-754 divider, result = A / B.
//                Restoring radix-2 quotient, one bit per clock, with a
//                start/done handshake and a fixed latency for every input.
//                Denormal operands are flushed to zero.
//                Compile-time option FPU_DIV_ROUND_EN selects
//                round-to-nearest-even; without it the quotient is truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_sp_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam logic [2:0]  c_ST_IDLE = 3'd0;
    localparam logic [2:0]  c_ST_PREP = 3'd1;
    localparam logic [2:0]  c_ST_ITER = 3'd2;
    localparam logic [2:0]  c_ST_NORM = 3'd3;
    localparam logic [2:0]  c_ST_DONE = 3'd4;

    localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;
    localparam logic [4:0]  c_ITER_LAST = 5'd25;

    logic [2:0]        r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [23:0]       r_mb;
    logic [24:0]       r_rem;
    logic [25:0]       r_q;
    logic [4:0]        r_cnt;
    logic              r_nan;
    logic              r_inf;
    logic              r_zero;
    logic              r_dbz;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_result;
    logic              r_dbz_out;

    // ---------------------------------------------------------------- unpack
    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic [22:0] w_fa;
    logic [22:0] w_fb;
    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_nan;
    logic        w_inf;
    logic        w_zero;
    logic        w_dbz;

    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_fa     = r_a[22:0];
    assign w_fb     = r_b[22:0];
    assign w_a_zero = (w_ea == 8'd0);
    assign w_b_zero = (w_eb == 8'd0);
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);

    // Special-case classes, already resolved in priority order so that at
    // most one of nan/inf/zero is set.
    assign w_nan  = w_a_nan | w_b_nan | (w_a_inf & w_b_inf) | (w_a_zero & w_b_zero);
    assign w_inf  = ~w_nan & (w_a_inf | w_b_zero);
    assign w_dbz  = ~w_nan & ~w_a_inf & ~w_a_zero & w_b_zero;
    assign w_zero = ~w_nan & ~w_inf & (w_a_zero | w_b_inf);

    // ------------------------------------------------------------- iteration
    // The partial remainder stays below 2*mb, so 25 bits suffice.
    logic        w_ge;
    logic [24:0] w_diff;
    logic [24:0] w_rem_sel;

    assign w_ge      = (r_rem >= {1'b0, r_mb});
    assign w_diff    = r_rem - {1'b0, r_mb};
    assign w_rem_sel = w_ge ? w_diff : r_rem;

    // --------------------------------------------------------- normalisation
    logic              w_q_msb;
    logic [22:0]       w_frac_pre;
    logic signed [9:0] w_exp_norm;
    logic [22:0]       w_frac_fin;
    logic signed [9:0] w_exp_fin;
    logic [31:0]       w_result;

    assign w_q_msb    = r_q[25];
    assign w_frac_pre = w_q_msb ? r_q[24:2] : r_q[23:1];
    assign w_exp_norm = w_q_msb ? r_exp : (r_exp - 10'sd1);

`ifdef FPU_DIV_ROUND_EN
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [23:0] w_frac_inc;

    assign w_guard    = w_q_msb ? r_q[1] : r_q[0];
    assign w_sticky   = (w_q_msb & r_q[0]) | (r_rem != 25'd0);
    assign w_round_up = w_guard & (w_sticky | w_frac_pre[0]);
    assign w_frac_inc = {1'b0, w_frac_pre} + {23'd0, w_round_up};
    // A carry out of the fraction wraps it to zero and bumps the exponent
    // before the range check, so a round-up can still overflow to infinity.
    assign w_frac_fin = w_frac_inc[22:0];
    assign w_exp_fin  = w_exp_norm + (w_frac_inc[23] ? 10'sd1 : 10'sd0);
`else
    assign w_frac_fin = w_frac_pre;
    assign w_exp_fin  = w_exp_norm;
`endif

    // Special cases override the computed quotient, then range checks apply.
    always_comb begin
        w_result = {r_sign, w_exp_fin[7:0], w_frac_fin};
        if (r_nan) begin
            w_result = c_QNAN;
        end else if (r_inf) begin
            w_result = {r_sign, 8'hFF, 23'd0};
        end else if (r_zero) begin
            w_result = {r_sign, 31'd0};
        end else if (w_exp_fin >= 10'sd255) begin
            w_result = {r_sign, 8'hFF, 23'd0};
        end else if (w_exp_fin <= 10'sd0) begin
            w_result = {r_sign, 31'd0};
        end
    end

    // Control FSM and datapath: capture, prepare, iterate, normalise, report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mb      <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_nan     <= 1'b0;
            r_inf     <= 1'b0;
            r_zero    <= 1'b0;
            r_dbz     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_dbz_out <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_PREP;
                    end
                end
                c_ST_PREP: begin
                    r_sign  <= r_a[31] ^ r_b[31];
                    r_exp   <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;
                    r_rem   <= {2'b01, w_fa};
                    r_mb    <= {1'b1, w_fb};
                    r_q     <= '0;
                    r_cnt   <= c_ITER_LAST;
                    r_nan   <= w_nan;
                    r_inf   <= w_inf;
                    r_zero  <= w_zero;
                    r_dbz   <= w_dbz;
                    r_state <= c_ST_ITER;
                end
                c_ST_ITER: begin
                    r_q   <= {r_q[24:0], w_ge};
                    r_rem <= w_rem_sel << 1;
                    if (r_cnt == 5'd0) begin
                        r_state <= c_ST_NORM;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                c_ST_NORM: begin
                    r_result  <= w_result;
                    r_dbz_out <= r_dbz;
                    r_done    <= 1'b1;
                    r_state   <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign div_by_zero = r_dbz_out;

endmodule
`default_nettype wire

// File: tb/tb_fpu_sp_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_sp_divider
//  Description : Self-checking bench for fpu_sp_divider. A behavioural model
//                computes each quotient with plain integer division and tracks
//                the handshake timing; directed operations carry
//                hand-computed literal results. Honours FPU_DIV_ROUND_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_sp_divider;

    localparam int c_LAT = 28;

`ifdef FPU_DIV_ROUND_EN
    localparam logic [31:0] c_THIRD = 32'h3EAA_AAAB;
`else
    localparam logic [31:0] c_THIRD = 32'h3EAA_AAAA;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    fpu_sp_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Quotient from the arithmetic rules: returns {div_by_zero, result}.
    function automatic logic [32:0] f_model(input logic [31:0] a, input logic [31:0] b);
        logic            s;
        int              ea;
        int              eb;
        int              e;
        logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        longint unsigned ma, mb, num, q, frac;
`ifdef FPU_DIV_ROUND_EN
        longint unsigned rem;
        logic            g;
        logic            st;
`endif
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 23'd0);
        b_inf  = (eb == 255) && (b[22:0] == 23'd0);
        a_nan  = (ea == 255) && (a[22:0] != 23'd0);
        b_nan  = (eb == 255) && (b[22:0] != 23'd0);
        if (a_nan || b_nan)                        return {1'b0, 32'h7FC0_0000};
        if ((a_inf && b_inf) || (a_zero && b_zero)) return {1'b0, 32'h7FC0_0000};
        if (a_inf)                                 return {1'b0, s, 8'hFF, 23'd0};
        if (b_zero)                                return {1'b1, s, 8'hFF, 23'd0};
        if (a_zero || b_inf)                       return {1'b0, s, 31'd0};
        ma  = 64'h80_0000 | 64'(a[22:0]);
        mb  = 64'h80_0000 | 64'(b[22:0]);
        num = ma << 25;
        q   = num / mb;
        e   = ea - eb + 127;
        if (q >= 64'h200_0000) begin
            frac = (q >> 2) & 64'h7F_FFFF;
        end else begin
            frac = (q >> 1) & 64'h7F_FFFF;
            e    = e - 1;
        end
`ifdef FPU_DIV_ROUND_EN
        rem = num % mb;
        if (q >= 64'h200_0000) begin
            g  = q[1];
            st = q[0] || (rem != 0);
        end else begin
            g  = q[0];
            st = (rem != 0);
        end
        if (g && (st || frac[0])) frac = frac + 1;
        if (frac == 64'h80_0000) begin
            frac = 0;
            e    = e + 1;
        end
`endif
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
        if (e <= 0)   return {1'b0, s, 31'd0};
        return {1'b0, s, 8'(e), frac[22:0]};
    endfunction

    // Timing model: an accepted start yields done 28 edges later, busy until
    // one edge after that; reset clears everything.
    logic        m_active = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [31:0] m_res = '0;
    logic        m_dbz = 1'b0;
    logic [32:0] m_calc;

    assign m_calc = f_model(m_a, m_b);

    // Reference model of the handshake and the held outputs.
    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_res    <= '0;
            m_dbz    <= 1'b0;
        end else if (m_active) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == c_LAT - 1) begin
                m_res <= m_calc[31:0];
                m_dbz <= m_calc[32];
            end
            if (m_cnt == c_LAT) m_active <= 1'b0;
        end else if (start) begin
            m_active <= 1'b1;
            m_cnt    <= 0;
            m_a      <= A;
            m_b      <= B;
        end
    end

    // Literal expectations posted by the driver, one per completing operation.
    logic [31:0] lit_res [64];
    logic        lit_dbz [64];
    logic        lit_has [64];
    int          op_wr = 0;
    int          op_rd = 0;
    logic        chk_en = 1'b0;
    logic        end_req = 1'b0;
    int          n_timeouts = 0;
    int          n_total = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_active && (m_cnt == c_LAT)));
            check("result", result, m_res);
            check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
            if (m_active && (m_cnt == c_LAT)) begin
                if ((op_rd < op_wr) && lit_has[op_rd]) begin
                    check("literal_result", result, lit_res[op_rd]);
                    check("literal_dbz", 32'(div_by_zero), 32'(lit_dbz[op_rd]));
                end
                op_rd++;
            end
            if (end_req) begin
                check("timeouts", 32'(n_timeouts), 32'd0);
                check("ops_completed", 32'(op_rd), 32'(op_wr));
                $display("%0d/%0d checks passed", n_pass, n_total);
                $finish;
            end
        end
    end

    // Present operands until the model shows acceptance.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int k;
        A     = a;
        B     = b;
        start = 1'b1;
        k     = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m_active && (m_cnt == 0)) && (k < 6));
        if (k >= 6) n_timeouts++;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!(m_active && (m_cnt == c_LAT)) && (k < 40)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) n_timeouts++;
    endtask

    task automatic post(input logic [31:0] res, input logic dbz, input logic has);
        lit_res[op_wr] = res;
        lit_dbz[op_wr] = dbz;
        lit_has[op_wr] = has;
        op_wr++;
    endtask

    // Ends on the done cycle, so a following call holds start through DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic dbz, input logic has);
        post(res, dbz, has);
        start_op(a, b);
        wait_done();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b1); // 6/2
        run_op(32'h3F80_0000, 32'h4040_0000, c_THIRD,       1'b0, 1'b1); // 1/3
        run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b1); // 1/0
        run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b1); // 0/0
        run_op(32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 1'b0, 1'b1); // -1/inf
        run_op(32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 1'b0, 1'b1); // overflow
        run_op(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 1'b1); // -6/2
        run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b1); // NaN/1
        run_op(32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b1); // inf/2
        run_op(32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b1); // inf/inf
        run_op(32'h0080_0000, 32'h4F00_0000, 32'h0000_0000, 1'b0, 1'b1); // underflow
        run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b1); // -0/2
        run_op(32'h4000_0000, 32'h0040_0000, 32'h7F80_0000, 1'b1, 1'b1); // 2/denormal
        run_op(32'h40A0_0000, 32'h3F00_0000, 32'h4120_0000, 1'b0, 1'b1); // 5/0.5
        run_op(32'h4049_0FDB, 32'h402D_F854, 32'h0, 1'b0, 1'b0);         // pi/e
        run_op(32'h3FFF_FFFF, 32'h3F80_0001, 32'h0, 1'b0, 1'b0);         // rounding carry
        run_op(32'h42F6_0000, 32'h4120_0000, 32'h0, 1'b0, 1'b0);         // 123/10
        run_op(32'h0100_0000, 32'h7E80_0000, 32'h0, 1'b0, 1'b0);         // deep underflow

        // New operands pulsed at edges 5 and 20 of a running operation.
        @(negedge clk);
        post(32'h4040_0000, 1'b0, 1'b1);
        start_op(32'h40C0_0000, 32'h4000_0000);
        repeat (4) @(negedge clk);
        A = 32'h3F80_0000; B = 32'h4040_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        A = 32'h7F00_0000; B = 32'h0000_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset in the middle of the iteration: no done, outputs cleared.
        @(negedge clk);
        @(negedge clk);
        start_op(32'h3F80_0000, 32'h4040_0000);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (35) @(negedge clk);
        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        end_req = 1'b1;
        repeat (5) @(negedge clk);
        $display("FAIL summary: not reached");
        $fatal(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
